key_search_scheduler: RTL and testbench

- Top-level brute-force controller for the RC4 key search.
- Shares the key space among NUM_CORES decoder cores. Each core uses a level core_start / core_finish handshake: the core holds finish while start is high and returns to idle after start drops.
- Hands out consecutive candidate keys, collects each core's pass/fail verdict and stops at the first valid key or at key-space exhaustion.
- Reports the result to the top-level display/LED logic.

---
 rtl/key_search_scheduler.sv | 171 +++++++++++++++++
 tb/tb_key_search_scheduler.sv | 499 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_search_scheduler.sv
// Brute-force RC4 key search scheduler: hands consecutive candidate keys to a
// pool of decoder cores over a level start/finish handshake, collects their
// verdicts and stops at the first valid key or once the key space is used up.
module key_search_scheduler #(
  parameter int unsigned           NUM_CORES = 4,
  parameter int unsigned           KEY_WIDTH = 24,
  parameter logic [KEY_WIDTH-1:0]  KEY_MAX   = 24'h3FFFFF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             search_start,
  output logic                             search_busy,
  output logic                             search_done,
  output logic                             key_found,
  output logic [KEY_WIDTH-1:0]             found_key,
  output logic [NUM_CORES-1:0]             core_start,
  output logic [NUM_CORES*KEY_WIDTH-1:0]   core_key,
  input  logic [NUM_CORES-1:0]             core_finish,
  input  logic [NUM_CORES-1:0]             core_key_valid
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;
  typedef enum logic [1:0] {SlotFree, SlotWait, SlotRelease} slot_e;

  // One extra bit so the counter steps past an all-ones KEY_MAX instead of wrapping.
  localparam logic [KEY_WIDTH:0] KeyLimit = {1'b0, KEY_MAX};
  localparam logic [KEY_WIDTH:0] KeyOne   = (KEY_WIDTH+1)'(1);

  state_e               state_q;
  slot_e                slot_q [NUM_CORES];
  logic [KEY_WIDTH:0]   next_key_q;
  logic                 found_q;

  logic                 keys_left;
  logic                 dispatch_en;
  logic                 win_en;
  logic                 all_free;
  logic                 disp_taken;
  logic                 win_taken;
  logic [NUM_CORES-1:0] slot_free;
  logic [NUM_CORES-1:0] verdict_valid;
  logic [NUM_CORES-1:0] dispatch_oh;
  logic [KEY_WIDTH-1:0] win_key;

  assign keys_left   = (next_key_q <= KeyLimit);
  assign dispatch_en = (state_q == StRun) && keys_left && !found_q;
  assign win_en      = !found_q && (|verdict_valid);
  assign all_free    = &slot_free;

  // Pick the lowest free slot for dispatch and the lowest valid verdict for the result.
  always_comb begin
    slot_free     = '0;
    verdict_valid = '0;
    dispatch_oh   = '0;
    win_key       = '0;
    disp_taken    = 1'b0;
    win_taken     = 1'b0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      slot_free[i]     = (slot_q[i] == SlotFree);
      verdict_valid[i] = (slot_q[i] == SlotWait) && core_finish[i] && core_key_valid[i];
      if (dispatch_en && slot_free[i] && !disp_taken) begin
        dispatch_oh[i] = 1'b1;
        disp_taken     = 1'b1;
      end
      if (verdict_valid[i] && !win_taken) begin
        win_key   = core_key[i*KEY_WIDTH +: KEY_WIDTH];
        win_taken = 1'b1;
      end
    end
  end

  // Top-level search FSM with its registered status outputs and key counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      next_key_q  <= '0;
      found_q     <= 1'b0;
      search_busy <= 1'b0;
      search_done <= 1'b0;
      key_found   <= 1'b0;
      found_key   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (search_start) begin
            state_q     <= StRun;
            next_key_q  <= '0;
            found_q     <= 1'b0;
            key_found   <= 1'b0;
            found_key   <= '0;
            search_busy <= 1'b1;
          end
        end
        StRun: begin
          if (|dispatch_oh) begin
            next_key_q <= next_key_q + KeyOne;
          end
          if (win_en) begin
            found_q   <= 1'b1;
            key_found <= 1'b1;
            found_key <= win_key;
          end
          if (found_q || !keys_left) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (win_en) begin
            found_q   <= 1'b1;
            key_found <= 1'b1;
            found_key <= win_key;
          end
          // Only finish once every core has been walked back to idle.
          if (all_free) begin
            state_q     <= StDone;
            search_busy <= 1'b0;
            search_done <= 1'b1;
          end
        end
        StDone: begin
          if (!search_start) begin
            state_q     <= StIdle;
            search_done <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Per-core slot FSMs driving the level start and the key handed to each core.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        slot_q[i] <= SlotFree;
      end
      core_start <= '0;
      core_key   <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        case (slot_q[i])
          SlotFree: begin
            if (dispatch_oh[i]) begin
              slot_q[i]                             <= SlotWait;
              core_start[i]                         <= 1'b1;
              core_key[i*KEY_WIDTH +: KEY_WIDTH]    <= next_key_q[KEY_WIDTH-1:0];
            end
          end
          SlotWait: begin
            if (core_finish[i]) begin
              slot_q[i]     <= SlotRelease;
              core_start[i] <= 1'b0;
            end
          end
          SlotRelease: begin
            if (!core_finish[i]) begin
              slot_q[i] <= SlotFree;
            end
          end
          default: begin
            slot_q[i]     <= SlotFree;
            core_start[i] <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_search_scheduler.sv
// Self-checking bench for key_search_scheduler: behavioural core models plus a
// log-based reference that derives the expected search result from the rules.
module tb_key_search_scheduler;

  localparam int          NC   = 4;
  localparam int          KW   = 24;
  localparam logic [23:0] KMAX = 24'd40;
  localparam int          SNC  = 2;
  localparam int          SKW  = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main DUT: four cores, small key space.
  logic               search_start;
  logic               search_busy;
  logic               search_done;
  logic               key_found;
  logic [KW-1:0]      found_key;
  logic [NC-1:0]      core_start;
  logic [NC*KW-1:0]   core_key;
  logic [NC-1:0]      core_finish;
  logic [NC-1:0]      core_key_valid;

  key_search_scheduler #(.NUM_CORES(NC), .KEY_WIDTH(KW), .KEY_MAX(KMAX)) dut (
    .clk            (clk),
    .reset          (reset),
    .search_start   (search_start),
    .search_busy    (search_busy),
    .search_done    (search_done),
    .key_found      (key_found),
    .found_key      (found_key),
    .core_start     (core_start),
    .core_key       (core_key),
    .core_finish    (core_finish),
    .core_key_valid (core_key_valid)
  );

  // Small DUT: 3-bit keys with an all-ones last key.
  logic               s_start;
  logic               s_busy;
  logic               s_done;
  logic               s_found;
  logic [SKW-1:0]     s_found_key;
  logic [SNC-1:0]     s_core_start;
  logic [SNC*SKW-1:0] s_core_key;
  logic [SNC-1:0]     s_core_finish;
  logic [SNC-1:0]     s_core_valid;

  key_search_scheduler #(.NUM_CORES(SNC), .KEY_WIDTH(SKW), .KEY_MAX(3'h7)) dut_small (
    .clk            (clk),
    .reset          (reset),
    .search_start   (s_start),
    .search_busy    (s_busy),
    .search_done    (s_done),
    .key_found      (s_found),
    .found_key      (s_found_key),
    .core_start     (s_core_start),
    .core_key       (s_core_key),
    .core_finish    (s_core_finish),
    .core_key_valid (s_core_valid)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Core model controls.
  int lat_min = 2;
  int lat_max = 6;
  bit hold_mode = 1'b0;
  bit go_all = 1'b0;
  int good_a = -1;
  int good_b = -1;

  function automatic bit is_good(input int k);
    return (k == good_a) || (k == good_b);
  endfunction

  // Main core models: accept on start, answer after a random delay (or on go_all),
  // hold finish until start drops. Verdict line is noise while finish is low.
  int cnt    [NC];
  bit busy_m [NC];
  int key_m  [NC];
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_finish    <= '0;
      core_key_valid <= '0;
      for (int i = 0; i < NC; i++) begin
        busy_m[i] <= 1'b0;
        cnt[i]    <= 0;
      end
    end else begin
      for (int i = 0; i < NC; i++) begin
        if (!core_finish[i]) core_key_valid[i] <= 1'($urandom);
        if (busy_m[i]) begin
          if (hold_mode ? go_all : (cnt[i] == 0)) begin
            core_finish[i]    <= 1'b1;
            core_key_valid[i] <= is_good(key_m[i]);
            busy_m[i]         <= 1'b0;
          end else if (cnt[i] > 0) begin
            cnt[i] <= cnt[i] - 1;
          end
        end else if (core_finish[i]) begin
          if (!core_start[i]) core_finish[i] <= 1'b0;
        end else if (core_start[i]) begin
          busy_m[i] <= 1'b1;
          cnt[i]    <= $urandom_range(lat_max, lat_min);
          key_m[i]  <= int'(core_key[i*KW +: KW]);
        end
      end
    end
  end

  // Small-DUT core models: never valid.
  int s_cnt    [SNC];
  bit s_busy_m [SNC];
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_core_finish <= '0;
      s_core_valid  <= '0;
      for (int i = 0; i < SNC; i++) begin
        s_busy_m[i] <= 1'b0;
        s_cnt[i]    <= 0;
      end
    end else begin
      for (int i = 0; i < SNC; i++) begin
        if (s_busy_m[i]) begin
          if (s_cnt[i] == 0) begin
            s_core_finish[i] <= 1'b1;
            s_core_valid[i]  <= 1'b0;
            s_busy_m[i]      <= 1'b0;
          end else begin
            s_cnt[i] <= s_cnt[i] - 1;
          end
        end else if (s_core_finish[i]) begin
          if (!s_core_start[i]) begin
            s_core_finish[i] <= 1'b0;
            s_core_valid[i]  <= 1'($urandom);
          end
        end else if (s_core_start[i]) begin
          s_busy_m[i] <= 1'b1;
          s_cnt[i]    <= $urandom_range(4, 0);
        end
      end
    end
  end

  // Event logs: dispatches (start rising) and verdicts (finish rising).
  typedef struct {int edge_n; int core; int key;} disp_t;
  typedef struct {int edge_n; int core; int key; bit valid;} verd_t;
  disp_t          dlog[$];
  verd_t          vlog[$];
  int             skeys[$];
  int             last_key [NC];
  logic [NC-1:0]  prev_start;
  logic [NC-1:0]  prev_fin;
  logic [SNC-1:0] s_prev;

  always begin
    @(posedge clk);
    #1;
    if (!reset) begin
      prev_start = '0;
      prev_fin   = '0;
      s_prev     = '0;
    end else begin
      for (int i = 0; i < NC; i++) begin
        if (core_start[i] && !prev_start[i]) begin
          last_key[i] = int'(core_key[i*KW +: KW]);
          dlog.push_back('{edge_n: cyc, core: i, key: last_key[i]});
        end
        if (core_finish[i] && !prev_fin[i])
          vlog.push_back('{edge_n: cyc, core: i, key: last_key[i], valid: core_key_valid[i]});
      end
      for (int i = 0; i < SNC; i++)
        if (s_core_start[i] && !s_prev[i]) skeys.push_back(int'(s_core_key[i*SKW +: SKW]));
      prev_start = core_start;
      prev_fin   = core_finish;
      s_prev     = s_core_start;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_main_done(input string name, input int budget);
    int k;
    k = 0;
    while (!search_done && k < budget) begin
      tick();
      k++;
    end
    n_checks++;
    if (search_done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s done_timeout: search_done=%b after %0d cycles, expected 1", name,
               search_done, budget);
    end
  endtask

  // Derive the expected outcome from the logs of the search that started after edge s0.
  task automatic check_main(input string name, input int s0);
    int n, bad, late, p_edge, p_core, p_key;
    bit have;
    logic [KW-1:0] exp_key;
    n = 0; bad = 0; late = 0; have = 1'b0; p_edge = 0; p_core = 0; p_key = 0;
    foreach (dlog[j]) if (dlog[j].edge_n > s0) begin
      if (dlog[j].key != n) bad++;
      n++;
    end
    foreach (vlog[j]) if (vlog[j].edge_n > s0 && vlog[j].valid) begin
      if (!have || vlog[j].edge_n < p_edge ||
          (vlog[j].edge_n == p_edge && vlog[j].core < p_core)) begin
        have = 1'b1; p_edge = vlog[j].edge_n; p_core = vlog[j].core; p_key = vlog[j].key;
      end
    end
    exp_key = have ? KW'(p_key) : '0;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s dispatch_order: %0d keys out of sequence in %0d dispatches, expected 0",
               name, bad, n);
    end
    n_checks++;
    if (key_found !== have) begin
      n_fail++;
      $display("FAIL %s key_found: got %b expected %b", name, key_found, have);
    end
    n_checks++;
    if (found_key !== exp_key) begin
      n_fail++;
      $display("FAIL %s found_key: got %0h expected %0h", name, found_key, exp_key);
    end
    if (have) begin
      foreach (dlog[j]) if (dlog[j].edge_n > s0 && dlog[j].edge_n > p_edge + 1) late++;
      n_checks++;
      if (late != 0) begin
        n_fail++;
        $display("FAIL %s late_dispatch: got %0d dispatches after the hit, expected 0", name, late);
      end
    end else begin
      n_checks++;
      if (n != int'(KMAX) + 1) begin
        n_fail++;
        $display("FAIL %s dispatch_count: got %0d expected %0d", name, n, int'(KMAX) + 1);
      end
    end
    n_checks++;
    if (core_start !== '0 || core_finish !== '0 || search_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s drained: core_start=%b core_finish=%b busy=%b, expected all 0", name,
               core_start, core_finish, search_busy);
    end
  endtask

  task automatic run_search(input string name);
    int s0;
    s0 = cyc;
    search_start = 1'b1;
    wait_main_done(name, 4000);
    check_main(name, s0);
    search_start = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    n_checks++;
    if ({search_busy, search_done, key_found} !== 3'b000 || found_key !== '0 ||
        core_start !== '0 || core_key !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b found=%b key=%0h start=%b ckey=%0h, expected 0",
               search_busy, search_done, key_found, found_key, core_start, core_key);
    end
    n_checks++;
    if ({s_busy, s_done, s_found} !== 3'b000 || s_found_key !== '0 || s_core_start !== '0) begin
      n_fail++;
      $display("FAIL reset_small: busy=%b done=%b found=%b start=%b, expected 0", s_busy, s_done,
               s_found, s_core_start);
    end
  endtask

  task automatic test_startup_order();
    logic [NC-1:0] exp_start;
    hold_mode = 1'b1;
    go_all    = 1'b0;
    search_start = 1'b1;
    tick();
    n_checks++;
    if (core_start !== '0 || search_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL startup_run_entry: start=%b busy=%b, expected 0000 and 1", core_start,
               search_busy);
    end
    for (int k = 0; k < NC; k++) begin
      tick();
      exp_start = NC'((1 << (k + 1)) - 1);
      n_checks++;
      if (core_start !== exp_start || core_key[k*KW +: KW] !== KW'(k)) begin
        n_fail++;
        $display("FAIL startup_slot%0d: start=%b key=%0h, expected %b and %0h", k, core_start,
                 core_key[k*KW +: KW], exp_start, k);
      end
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (core_start !== '0 || search_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL startup_async_reset: start=%b busy=%b, expected 0", core_start, search_busy);
    end
    search_start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    hold_mode = 1'b1;
    search_start = 1'b1;
    repeat (4) tick();
    n_checks++;
    if (core_start !== 4'b0111) begin
      n_fail++;
      $display("FAIL reset_mid_waiting: start=%b, expected 0111", core_start);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (core_start !== '0 || search_busy !== 1'b0 || core_key !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_async: start=%b busy=%b key=%0h, expected 0", core_start,
               search_busy, core_key);
    end
    search_start = 1'b0;
    tick();
    reset     = 1'b1;
    hold_mode = 1'b0;
    good_a    = 7;
    good_b    = -1;
    tick();
    run_search("restart_after_reset");
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      lat_min = $urandom_range(3, 0);
      lat_max = lat_min + $urandom_range(12, 0);
      good_a  = (it == 0) ? -1 : int'($urandom_range(int'(KMAX), 0));
      good_b  = (it % 2 == 1) ? int'($urandom_range(int'(KMAX), 0)) : -1;
      run_search($sformatf("random%0d", it));
    end
  endtask

  task automatic test_simultaneous();
    int s0, k;
    hold_mode = 1'b1;
    go_all    = 1'b0;
    good_a    = 1;
    good_b    = 2;
    s0 = cyc;
    search_start = 1'b1;
    k = 0;
    while (core_start !== 4'hF && k < 20) begin
      tick();
      k++;
    end
    go_all = 1'b1;
    wait_main_done("simultaneous", 200);
    check_main("simultaneous", s0);
    n_checks++;
    if (found_key !== 24'd1) begin
      n_fail++;
      $display("FAIL simultaneous_lowest: got %0h expected 1", found_key);
    end
    search_start = 1'b0;
    hold_mode = 1'b0;
    go_all    = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_done_hold();
    int s0;
    lat_min = 1;
    lat_max = 5;
    good_a  = 3;
    good_b  = -1;
    s0 = cyc;
    search_start = 1'b1;
    wait_main_done("done_hold", 2000);
    check_main("done_hold", s0);
    for (int k = 0; k < 20; k++) begin
      tick();
      n_checks++;
      if (search_done !== 1'b1 || core_start !== '0 || search_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL done_hold_cycle%0d: done=%b start=%b busy=%b, expected 1 0 0", k,
                 search_done, core_start, search_busy);
      end
    end
    search_start = 1'b0;
    tick();
    n_checks++;
    if (search_done !== 1'b0 || search_busy !== 1'b0 || key_found !== 1'b1) begin
      n_fail++;
      $display("FAIL done_exit: done=%b busy=%b found=%b, expected 0 0 1", search_done,
               search_busy, key_found);
    end
    good_a = -1;
    s0 = cyc;
    search_start = 1'b1;
    tick();
    n_checks++;
    if (key_found !== 1'b0 || found_key !== '0 || search_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_clear: found=%b key=%0h busy=%b, expected 0 0 1", key_found,
               found_key, search_busy);
    end
    wait_main_done("restart_run", 4000);
    check_main("restart_run", s0);
    search_start = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_exhaust_small();
    int base, k, bad;
    base = skeys.size();
    s_start = 1'b1;
    k = 0;
    while (!s_done && k < 2000) begin
      tick();
      k++;
    end
    n_checks++;
    if (s_done !== 1'b1) begin
      n_fail++;
      $display("FAIL small_done: s_done=%b after %0d cycles, expected 1", s_done, k);
    end
    n_checks++;
    if (skeys.size() - base != 8) begin
      n_fail++;
      $display("FAIL small_count: got %0d dispatches expected 8", skeys.size() - base);
    end
    bad = 0;
    for (int j = base; j < skeys.size(); j++) if (skeys[j] != j - base) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL small_order: %0d keys out of sequence, expected 0", bad);
    end
    n_checks++;
    if (s_found !== 1'b0 || s_found_key !== '0 || s_core_start !== '0 || s_core_finish !== '0) begin
      n_fail++;
      $display("FAIL small_result: found=%b key=%0h start=%b fin=%b, expected 0", s_found,
               s_found_key, s_core_start, s_core_finish);
    end
    repeat (5) tick();
    n_checks++;
    if (s_done !== 1'b1 || skeys.size() - base != 8) begin
      n_fail++;
      $display("FAIL small_no_wrap: done=%b dispatches=%0d, expected 1 and 8", s_done,
               skeys.size() - base);
    end
    s_start = 1'b0;
    tick();
    n_checks++;
    if (s_done !== 1'b0) begin
      n_fail++;
      $display("FAIL small_exit: s_done=%b expected 0", s_done);
    end
  endtask

  initial begin
    search_start = 1'b0;
    s_start      = 1'b0;
    repeat (3) tick();
    test_reset();
    reset = 1'b1;
    tick();
    test_startup_order();
    test_reset_mid();
    test_random();
    test_simultaneous();
    test_done_hold();
    test_exhaust_small();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
